fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/riscv_pkg.sv | 35 +++
 rtl/pc_gen.sv | 37 +++
 rtl/fetch_stage.sv | 152 +++++++++++++++
 tb/tb_fetch_stage.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared definitions for the instruction fetch front end:
//               datapath width, the canonical NOP encoding, the fetch FSM
//               state encoding and the next-PC source select.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Address/data width. Only 32 is supported by the fetch datapath.
    localparam int XLEN = 32;

    // addi x0, x0, 0 : presented on the decode interface out of reset.
    localparam logic [XLEN-1:0] c_nop_instr = 32'h0000_0013;

    // Fetch FSM states.
    //   REQ   : issue a request at pc when the output buffer can take it
    //   WAIT  : one request outstanding, waiting for its response
    //   DRAIN : outstanding request was flushed, swallow its response
    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    // Next-PC source select for pc_gen.
    typedef enum logic [1:0] {
        PC_HOLD     = 2'd0,
        PC_INCR     = 2'd1,
        PC_REDIRECT = 2'd2
    } pc_sel_e;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : pc_gen
// Description : Combinational next-PC generator. Selects between holding the
//               current PC, advancing by one instruction word (wrapping mod
//               2^32), or loading a redirect target with the byte offset
//               bits cleared so every fetch address is word aligned.
// Ports       : pc          - current fetch PC
//               sel         - next-PC source (hold / +4 / redirect)
//               redirect_pc - redirect target, may be unaligned
//               next_pc     - PC to load on the next rising edge
// Revision    : 1.0 - initial release
// ============================================================================
module pc_gen
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] pc,
    input  pc_sel_e         sel,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] next_pc
);

    localparam logic [XLEN-1:0] c_pc_step    = XLEN'(4);
    localparam logic [XLEN-1:0] c_align_mask = ~XLEN'(3);

    always_comb begin
        next_pc = pc;
        case (sel)
            // Natural overflow of the adder gives the 0xFFFF_FFFC -> 0 wrap.
            PC_INCR:     next_pc = pc + c_pc_step;
            PC_REDIRECT: next_pc = redirect_pc & c_align_mask;
            default:     next_pc = pc;
        endcase
    end

endmodule : pc_gen
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Single-outstanding-request instruction fetch stage with a
//               one-entry output buffer towards decode and redirect flush.
// Ports       : clk, rst_n                     - clock, async active-low reset
//               imem_req_valid/addr/ready      - fetch request handshake
//               imem_resp_valid/data           - fetch response
//               id_valid/instr/pc, id_ready    - decode-side buffer handshake
//               redirect_valid/pc              - branch/jump redirect (flush)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          XLEN     = 32
)(
    input  logic            clk,
    input  logic            rst_n,

    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,

    output logic            id_valid,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_pc,
    input  logic            id_ready,

    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    fetch_state_e    r_state;
    fetch_state_e    w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] w_pc_next;
    pc_sel_e         w_pc_sel;

    logic            r_id_valid;
    logic [XLEN-1:0] r_id_instr;
    logic [XLEN-1:0] r_id_pc;
    logic            w_id_valid_next;
    logic            w_load;
    logic            w_req_valid;

    // ------------------------------------------------------------------
    // Next-PC selection
    // ------------------------------------------------------------------
    pc_gen u_pc_gen (
        .pc          (r_pc),
        .sel         (w_pc_sel),
        .redirect_pc (redirect_pc),
        .next_pc     (w_pc_next)
    );

    // ------------------------------------------------------------------
    // Next-state / control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next    = r_state;
        w_pc_sel        = PC_HOLD;
        w_load          = 1'b0;
        w_req_valid     = 1'b0;
        // Buffer empties when decode consumes it, unless refilled below.
        w_id_valid_next = r_id_valid && !id_ready;

        case (r_state)
            REQ: begin
                // Only fetch when the buffer has room by the time the
                // response lands; rst_n gating keeps the request quiet while
                // reset is held even though the state already reads REQ.
                w_req_valid = rst_n && (!r_id_valid || id_ready) && !redirect_valid;
                if (w_req_valid && imem_req_ready) begin
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                if (imem_resp_valid) begin
                    w_load          = 1'b1;
                    w_id_valid_next = 1'b1;
                    w_pc_sel        = PC_INCR;
                    w_state_next    = REQ;
                end
            end
            DRAIN: begin
                // Response belongs to a flushed request: drop it.
                if (imem_resp_valid) begin
                    w_state_next = REQ;
                end
            end
            default: begin
                w_state_next = REQ;
            end
        endcase

        // Redirect overrides everything: flush the buffer, retarget pc and
        // remember whether a flushed request is still in flight.
        if (redirect_valid) begin
            w_pc_sel        = PC_REDIRECT;
            w_load          = 1'b0;
            w_id_valid_next = 1'b0;
            if (r_state == REQ || imem_resp_valid) begin
                w_state_next = REQ;
            end else begin
                w_state_next = DRAIN;
            end
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= REQ;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // PC and output buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_id_valid <= 1'b0;
            r_id_instr <= c_nop_instr;
            r_id_pc    <= '0;
        end else begin
            r_pc       <= w_pc_next;
            r_id_valid <= w_id_valid_next;
            // Data/pc only move on a load, so they hold across stalls.
            if (w_load) begin
                r_id_instr <= imem_resp_data;
                r_id_pc    <= r_pc;
            end
        end
    end

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_pc;
    assign id_valid       = r_id_valid;
    assign id_instr       = r_id_instr;
    assign id_pc          = r_id_pc;

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed self-checking bench for fetch_stage with
//               RESET_PC = 0x100. Inputs change 1 time unit after each rising
//               edge, outputs are sampled 1 time unit later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_stage #(
        .RESET_PC (32'h0000_0100),
        .XLEN     (32)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .id_valid        (id_valid),
        .id_instr        (id_instr),
        .id_pc           (id_pc),
        .id_ready        (id_ready),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n           = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        id_ready        = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;

        // ---- reset values ----
        repeat (2) cyc();
        #1;
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        check("rst_id_valid",  {31'b0, id_valid},       32'h0);
        check("rst_id_instr",  id_instr,                32'h0000_0013);
        check("rst_id_pc",     id_pc,                   32'h0);
        cyc();

        // ---- first fetch, zero-wait memory ----
        rst_n          = 1'b1;
        imem_req_ready = 1'b1;
        #1;
        check("first_req_valid", {31'b0, imem_req_valid}, 32'h1);
        check("first_req_addr",  imem_req_addr,           32'h0000_0100);
        cyc();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0050_0093;
        #1;
        check("wait_no_req",      {31'b0, imem_req_valid}, 32'h0);
        check("id_valid_not_yet", {31'b0, id_valid},       32'h0);
        cyc();
        imem_resp_valid = 1'b0;
        #1;
        check("load_id_valid", {31'b0, id_valid}, 32'h1);
        check("load_id_instr", id_instr,          32'h0050_0093);
        check("load_id_pc",    id_pc,             32'h0000_0100);

        // ---- decode stall for 5 more cycles ----
        repeat (5) begin
            cyc();
            check("stall_id_valid",  {31'b0, id_valid},       32'h1);
            check("stall_id_instr",  id_instr,                32'h0050_0093);
            check("stall_id_pc",     id_pc,                   32'h0000_0100);
            check("stall_no_req",    {31'b0, imem_req_valid}, 32'h0);
        end
        cyc();
        id_ready       = 1'b1;
        imem_req_ready = 1'b1;
        #1;
        check("release_req_valid", {31'b0, imem_req_valid}, 32'h1);
        check("release_req_addr",  imem_req_addr,           32'h0000_0104);
        cyc();

        // ---- redirect to 0x203 while waiting, stale response later ----
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0203;
        #1;
        check("consumed_id_valid", {31'b0, id_valid},       32'h0);
        check("redir_wait_no_req", {31'b0, imem_req_valid}, 32'h0);
        cyc();
        redirect_valid = 1'b0;
        #1;
        check("drain_no_req",   {31'b0, imem_req_valid}, 32'h0);
        check("drain_id_valid", {31'b0, id_valid},       32'h0);
        cyc();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        #1;
        check("drain_resp_no_req", {31'b0, imem_req_valid}, 32'h0);
        cyc();
        imem_resp_valid = 1'b0;
        imem_req_ready  = 1'b1;
        #1;
        check("stale_not_shown",    {31'b0, id_valid},       32'h0);
        check("after_drain_req",    {31'b0, imem_req_valid}, 32'h1);
        check("after_drain_addr",   imem_req_addr,           32'h0000_0200);
        cyc();

        // ---- redirect coincident with response ----
        imem_req_ready  = 1'b0;
        redirect_valid  = 1'b1;
        redirect_pc     = 32'h0000_0400;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h1111_1111;
        #1;
        check("coinc_no_req", {31'b0, imem_req_valid}, 32'h0);
        cyc();
        redirect_valid  = 1'b0;
        imem_resp_valid = 1'b0;
        #1;
        check("coinc_id_valid", {31'b0, id_valid},       32'h0);
        check("coinc_req",      {31'b0, imem_req_valid}, 32'h1);
        check("coinc_addr",     imem_req_addr,           32'h0000_0400);

        // ---- redirect (unaligned) to top of address space ----
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        #1;
        check("redir_blocks_req", {31'b0, imem_req_valid}, 32'h0);
        cyc();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        #1;
        check("top_req_valid", {31'b0, imem_req_valid}, 32'h1);
        check("top_req_addr",  imem_req_addr,           32'hFFFF_FFFC);
        cyc();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h00A0_0113;
        #1;
        cyc();
        imem_resp_valid = 1'b0;
        imem_req_ready  = 1'b1;
        #1;
        check("wrap_id_valid",  {31'b0, id_valid},       32'h1);
        check("wrap_id_pc",     id_pc,                   32'hFFFF_FFFC);
        check("wrap_id_instr",  id_instr,                32'h00A0_0113);
        check("wrap_req_valid", {31'b0, imem_req_valid}, 32'h1);
        check("wrap_req_addr",  imem_req_addr,           32'h0000_0000);
        cyc();

        // ---- asynchronous reset mid-WAIT ----
        imem_req_ready = 1'b0;
        #1;
        check("wrap_consumed", {31'b0, id_valid}, 32'h0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
        check("mid_rst_id_valid",  {31'b0, id_valid},       32'h0);
        check("mid_rst_id_instr",  id_instr,                32'h0000_0013);
        check("mid_rst_id_pc",     id_pc,                   32'h0);
        cyc();
        rst_n          = 1'b1;
        imem_req_ready = 1'b1;
        #1;
        check("post_rst_req_valid", {31'b0, imem_req_valid}, 32'h1);
        check("post_rst_req_addr",  imem_req_addr,           32'h0000_0100);
        cyc();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0010_0073;
        #1;
        cyc();
        imem_resp_valid = 1'b0;
        #1;
        check("post_rst_id_pc",    id_pc,    32'h0000_0100);
        check("post_rst_id_instr", id_instr, 32'h0010_0073);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_stage
`default_nettype wire
